// File: rtl/wrr_sched4_pkg.sv
// Shared definitions for the four-way weighted round-robin scheduler.
// Optional starvation guard is enabled by defining WRR_STARVE_EN.
package wrr_sched4_pkg;

  localparam int NREQ_DEF       = 4;
  localparam int WT_W_DEF       = 5;
  localparam int STARVE_LIM_DEF = 31;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_OWN  = 1'b1
  } state_e;

  // One-hot to index; returns 0 for an all-zero vector.
  function automatic logic [1:0] oh2idx(input logic [3:0] oh);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (oh[i]) idx = idx | 2'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/wrr_sched4_rr_pick4.sv
// Rotate-priority picker: first eligible client after `last`, wrapping,
// with `last` itself considered at lowest priority.
import wrr_sched4_pkg::*;

module rr_pick4 (
  input  logic [3:0] eligible,
  input  logic [1:0] last,
  output logic       pick_vld,
  output logic [1:0] pick_id
);

  logic [1:0] idx;

  // Scan from farthest offset to nearest so the nearest eligible wins.
  always_comb begin
    pick_vld = 1'b0;
    pick_id  = last;
    idx      = last;
    for (int k = 4; k >= 1; k--) begin
      idx = last + k[1:0];
      if (eligible[idx]) begin
        pick_vld = 1'b1;
        pick_id  = idx;
      end
    end
  end

endmodule

// File: rtl/wrr_sched4.sv
// Four-requester weighted round-robin scheduler with credit bursts,
// registered one-hot grant and downstream backpressure.
// Define WRR_STARVE_EN to add per-client wait counters that let a
// starved client win the next arbitration ahead of round-robin order.
import wrr_sched4_pkg::*;

module wrr_sched4 #(
  parameter int NREQ       = NREQ_DEF,
  parameter int WT_W       = WT_W_DEF,
  parameter int STARVE_LIM = STARVE_LIM_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*WT_W-1:0] wt,
  input  logic                 wt_ld,
  input  logic                 gnt_busy,
  output logic [NREQ-1:0]      gnt,
  output logic                 gnt_vld,
  output logic [1:0]           gnt_id,
  output logic [WT_W-1:0]      cred_left
);

  state_e                     state_q, state_d;
  logic [NREQ-1:0]            gnt_q, gnt_d;
  logic [WT_W-1:0]            cred_q, cred_d, cred_dec;
  logic [1:0]                 last_q, last_d;
  logic [NREQ-1:0][WT_W-1:0]  wt_reg_q, wt_reg_d;

  logic [NREQ-1:0] elig;
  logic [1:0]      owner, ptr, rr_id, sel_id;
  logic            rr_vld, sel_vld, keep;

  assign owner = oh2idx(gnt_q);
  // While owning, rotation starts after the current owner so a hand-off
  // never re-picks it ahead of others.
  assign ptr   = (state_q == S_OWN) ? owner : last_q;

  // A zero-weight client can never be granted.
  always_comb begin
    elig = '0;
    for (int i = 0; i < NREQ; i++) elig[i] = req[i] && (wt_reg_q[i] != '0);
  end

  rr_pick4 u_pick (
    .eligible (elig),
    .last     (ptr),
    .pick_vld (rr_vld),
    .pick_id  (rr_id)
  );

`ifdef WRR_STARVE_EN
  logic [NREQ-1:0][WT_W-1:0] wait_q, wait_d;
  logic [NREQ-1:0]           starving;
  logic                      st_vld;
  logic [1:0]                st_id;

  // Lowest-index starved client overrides round-robin order.
  always_comb begin
    st_vld = 1'b0;
    st_id  = 2'd0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      starving[i] = elig[i] && (int'(wait_q[i]) >= STARVE_LIM);
      if (starving[i]) begin
        st_vld = 1'b1;
        st_id  = 2'(i);
      end
    end
    sel_vld = st_vld | rr_vld;
    sel_id  = st_vld ? st_id : rr_id;
  end

  // Wait counters saturate; cleared on grant or when the request drops.
  always_comb begin
    wait_d = wait_q;
    for (int i = 0; i < NREQ; i++) begin
      if (!req[i] || gnt_d[i])                              wait_d[i] = '0;
      else if (elig[i] && !gnt_q[i] && (wait_q[i] != '1))   wait_d[i] = wait_q[i] + 1'b1;
    end
  end

  // Wait counter state.
  always_ff @(posedge clk) begin
    if (reset) wait_q <= '0;
    else       wait_q <= wait_d;
  end
`else
  assign sel_vld = rr_vld;
  assign sel_id  = rr_id;
`endif

  // Arbitration: keep the owner while it requests and has credit left,
  // otherwise hand off (or go idle) in the same cycle as the last beat.
  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    cred_d   = cred_q;
    last_d   = last_q;
    wt_reg_d = wt_ld ? wt : wt_reg_q;
    cred_dec = ((state_q == S_OWN) && (cred_q != '0)) ? cred_q - 1'b1 : cred_q;
    keep     = (state_q == S_OWN) && req[owner] && (cred_dec != '0);
    if (!gnt_busy) begin
      if (keep) begin
        cred_d = cred_dec;
      end else begin
        if (state_q == S_OWN) last_d = owner;
        gnt_d = '0;
        if (sel_vld) begin
          state_d       = S_OWN;
          gnt_d[sel_id] = 1'b1;
          cred_d        = wt_reg_q[sel_id];
        end else begin
          state_d = S_IDLE;
          cred_d  = '0;
        end
      end
    end
  end

  // Scheduler state with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      gnt_q    <= '0;
      cred_q   <= '0;
      last_q   <= 2'd3;
      wt_reg_q <= '0;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      cred_q   <= cred_d;
      last_q   <= last_d;
      wt_reg_q <= wt_reg_d;
    end
  end

  assign gnt       = gnt_q;
  assign gnt_vld   = |gnt_q;
  assign gnt_id    = owner;
  assign cred_left = cred_q;

endmodule

// File: tb/tb_wrr_sched4.sv
// Directed self-checking bench for wrr_sched4 (default build).
module tb_wrr_sched4;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req;
  logic [19:0] wt;
  logic        wt_ld;
  logic        gnt_busy;
  logic [3:0]  gnt;
  logic        gnt_vld;
  logic [1:0]  gnt_id;
  logic [4:0]  cred_left;

  int total  = 0;
  int passed = 0;

  wrr_sched4 dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .wt        (wt),
    .wt_ld     (wt_ld),
    .gnt_busy  (gnt_busy),
    .gnt       (gnt),
    .gnt_vld   (gnt_vld),
    .gnt_id    (gnt_id),
    .cred_left (cred_left)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic logic [19:0] pack(input logic [4:0] c3, input logic [4:0] c2,
                                       input logic [4:0] c1, input logic [4:0] c0);
    return {c3, c2, c1, c0};
  endfunction

  // Expected owner/credit sequence for weights 3,1,2,0 with all requesting.
  logic [1:0] exp_id [10] = '{0, 0, 0, 1, 2, 2, 0, 0, 0, 1};
  logic [4:0] exp_cr [10] = '{3, 2, 1, 1, 2, 1, 3, 2, 1, 1};

  initial begin
    reset = 1'b1; req = '0; wt = '0; wt_ld = 1'b0; gnt_busy = 1'b0;
    tick(); tick();
    chk("rst_gnt", 32'(gnt), 0);
    chk("rst_vld", 32'(gnt_vld), 0);
    chk("rst_id", 32'(gnt_id), 0);
    chk("rst_cred", 32'(cred_left), 0);

    // Weighted round-robin with client 3 at zero weight.
    reset = 1'b0; wt = pack(0, 2, 1, 3); wt_ld = 1'b1;
    tick();
    chk("ld_idle_gnt", 32'(gnt), 0);
    wt_ld = 1'b0; req = 4'b1111;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk($sformatf("wrr_id%0d", i), 32'(gnt_id), 32'(exp_id[i]));
      chk($sformatf("wrr_cred%0d", i), 32'(cred_left), 32'(exp_cr[i]));
      chk($sformatf("wrr_vld%0d", i), 32'(gnt_vld), 1);
      chk($sformatf("wrr_no3_%0d", i), 32'(gnt[3]), 0);
    end

    // Reset while client 1 owns: everything clears on the next edge.
    chk("pre_rst_gnt", 32'(gnt), 32'h2);
    reset = 1'b1;
    tick();
    chk("mid_rst_gnt", 32'(gnt), 0);
    chk("mid_rst_vld", 32'(gnt_vld), 0);
    chk("mid_rst_cred", 32'(cred_left), 0);
    reset = 1'b0; wt_ld = 1'b1;
    tick();
    chk("post_rst_nowt", 32'(gnt), 0);
    wt_ld = 1'b0;
    tick();
    chk("post_rst_first", 32'(gnt), 32'h1);
    chk("post_rst_cred", 32'(cred_left), 3);

    // Backpressure during client 0's second beat.
    tick();
    chk("busy_pre_cred", 32'(cred_left), 2);
    gnt_busy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("busy_gnt%0d", i), 32'(gnt), 32'h1);
      chk($sformatf("busy_cred%0d", i), 32'(cred_left), 2);
    end
    gnt_busy = 1'b0;
    tick();
    chk("busy_res_gnt", 32'(gnt), 32'h1);
    chk("busy_res_cred", 32'(cred_left), 1);
    tick();
    chk("busy_hand_gnt", 32'(gnt), 32'h2);
    chk("busy_hand_cred", 32'(cred_left), 1);

    // Only client 2; reselect coincides with wt_ld so old weight 2 applies.
    req = 4'b0100; wt = pack(1, 1, 1, 1); wt_ld = 1'b1;
    tick();
    chk("solo_gnt0", 32'(gnt), 32'h4);
    chk("solo_oldwt", 32'(cred_left), 2);
    wt_ld = 1'b0;
    tick();
    chk("solo_cred1", 32'(cred_left), 1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("solo_gnt_r%0d", i), 32'(gnt), 32'h4);
      chk($sformatf("solo_cred_r%0d", i), 32'(cred_left), 1);
    end

    // Owner drops request mid-burst.
    req = 4'b0000; wt = pack(1, 1, 4, 1); wt_ld = 1'b1;
    tick();
    chk("idle_gnt", 32'(gnt), 0);
    chk("idle_vld", 32'(gnt_vld), 0);
    wt_ld = 1'b0; req = 4'b0010;
    tick();
    chk("c1_gnt", 32'(gnt), 32'h2);
    chk("c1_cred", 32'(cred_left), 4);
    req = 4'b1000;
    tick();
    chk("drop_gnt", 32'(gnt), 32'h8);
    chk("drop_id", 32'(gnt_id), 3);
    chk("drop_cred", 32'(cred_left), 1);

    // wt_ld during a burst leaves the running burst alone.
    req = 4'b0001; wt = pack(1, 1, 1, 3); wt_ld = 1'b1;
    tick();
    chk("w5_gnt", 32'(gnt), 32'h1);
    chk("w5_oldwt", 32'(cred_left), 1);
    wt_ld = 1'b0;
    tick();
    chk("w5_newwt", 32'(cred_left), 3);
    wt = pack(1, 1, 1, 2); wt_ld = 1'b1;
    tick();
    chk("w5_burst_c2", 32'(cred_left), 2);
    wt_ld = 1'b0;
    tick();
    chk("w5_burst_c1", 32'(cred_left), 1);
    tick();
    chk("w5_next_c2", 32'(cred_left), 2);
    chk("w5_next_gnt", 32'(gnt), 32'h1);
    tick();
    chk("w5_next_c1", 32'(cred_left), 1);
    tick();
    chk("w5_next2_c2", 32'(cred_left), 2);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
